// File: rtl/seq_adder.sv
// seq_adder -- digit-serial adder.
//
// Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, so one
// addition takes N = WIDTH/DIGIT cycles in RUN followed by a single DONE
// cycle. WIDTH must be an integer multiple of DIGIT.
//
// Ports:
//   clk    in   single clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset, wins over start
//   start  in   begin an addition (accepted in IDLE or DONE only)
//   a, b   in   WIDTH-bit operands, latched when start is accepted
//   cin    in   carry into bit 0, latched with the operands
//   busy   out  high during the N RUN cycles
//   done   out  one-cycle pulse while sum/cout hold a fresh result
//   sum    out  registered WIDTH-bit result, held between operations
//   cout   out  carry out of bit WIDTH-1, held like sum
//   ovf    out  two's-complement overflow, only when SEQ_ADDER_OVF_EN is
//               defined; absent otherwise
//
// Build option: define SEQ_ADDER_OVF_EN to add the ovf port and its logic.

module seq_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_full;
  logic             carry_reg;
  logic [KW-1:0]    k;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_s;
  logic             dig_cout;
  logic             dig_cmsb;
  logic             ripple_c;

  logic             last_digit;
  logic             accept;

  // A new operation may only be taken when no addition is in flight.
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign last_digit = (k == KW'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE can chain straight into RUN so back-to-back
  // operations need no IDLE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last_digit ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Select digit k of the latched operands.
  always_comb begin
    dig_a = a_reg[k*DIGIT +: DIGIT];
    dig_b = b_reg[k*DIGIT +: DIGIT];
  end

  // DIGIT-bit ripple of full-adder cells. dig_cmsb is the carry into the
  // top cell; on the last digit it is the carry into bit WIDTH-1, which the
  // overflow flag needs.
  always_comb begin
    ripple_c = carry_reg;
    dig_cmsb = carry_reg;
    dig_s    = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        dig_cmsb = ripple_c;
      end
      dig_s[i] = dig_a[i] ^ dig_b[i] ^ ripple_c;
      ripple_c = (dig_a[i] & dig_b[i]) | (dig_a[i] & ripple_c) |
                 (dig_b[i] & ripple_c);
    end
    dig_cout = ripple_c;
  end

  // Partial result with the current digit merged in; on the last digit this
  // is the complete sum, so it can be published in the same edge.
  always_comb begin
    res_full = res_reg;
    res_full[k*DIGIT +: DIGIT] = dig_s;
  end

  // Operand latch, digit sequencing and internal carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      k         <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      res_reg   <= '0;
      carry_reg <= cin;
      k         <= '0;
    end else if (state == RUN) begin
      res_reg   <= res_full;
      carry_reg <= dig_cout;
      k         <= last_digit ? '0 : k + KW'(1);
    end
  end

  // Visible result registers: written only on the edge that enters DONE,
  // so they hold through subsequent IDLE and RUN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if ((state == RUN) && last_digit) begin
      sum  <= res_full;
      cout <= dig_cout;
    end
  end

`ifdef SEQ_ADDER_OVF_EN
  // Overflow = carry into the sign bit XOR carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((state == RUN) && last_digit) begin
      ovf <= dig_cmsb ^ dig_cout;
    end
  end
`else
  // Without the overflow output the top-cell carry has no consumer.
  logic unused_cmsb;
  assign unused_cmsb = dig_cmsb;
`endif

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder -- directed, table-driven bench for seq_adder.
//
// Instantiates a 32/8 adder (four digits) and an 8/8 adder (single digit).
// The vector table covers carry chains, digit-boundary carries and overflow;
// hand-written sequences cover ignored start, back-to-back starts, reset
// mid-operation and reset priority over start.
// Define SEQ_ADDER_OVF_EN to also check the ovf output.

module tb_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cin8;
  logic        busy8;
  logic        done8;
  logic [7:0]  sum8;
  logic        cout8;

`ifdef SEQ_ADDER_OVF_EN
  logic        ovf;
  logic        ovf8;
`endif

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  seq_adder #(.WIDTH(32), .DIGIT(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SEQ_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  seq_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SEQ_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Called at a falling edge; returns one falling edge after start was
  // sampled, i.e. in the first RUN cycle.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input logic cv);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done rises (bounded), and busy cycles seen.
  task automatic waitDone(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int cyc;
    int bcyc;
    applyStimulus(v.a, v.b, v.cin);
    waitDone(cyc, bcyc);
    checkOutput($sformatf("v%0d latency", idx), 32'(cyc), 32'd4);
    checkOutput($sformatf("v%0d busy_cycles", idx), 32'(bcyc), 32'd4);
    checkOutput($sformatf("v%0d busy_in_done", idx), {31'd0, busy}, 32'd0);
    checkOutput($sformatf("v%0d sum", idx), sum, v.s);
    checkOutput($sformatf("v%0d cout", idx), {31'd0, cout}, {31'd0, v.co});
`ifdef SEQ_ADDER_OVF_EN
    checkOutput($sformatf("v%0d ovf", idx), {31'd0, ovf}, {31'd0, v.ov});
`endif
    @(negedge clk);
    checkOutput($sformatf("v%0d done_pulse", idx), {31'd0, done}, 32'd0);
    checkOutput($sformatf("v%0d sum_hold", idx), sum, v.s);
  endtask

  initial begin
    int cyc;
    int bcyc;
    int pulses;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
    vecs[8] = '{32'hDEADBEEF, 32'h12345678, 1'b0, 32'hF0E21567, 1'b0, 1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    cin8   = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset sum", sum, 32'd0);
    checkOutput("reset cout", {31'd0, cout}, 32'd0);
`ifdef SEQ_ADDER_OVF_EN
    checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      runVector(vecs[i], i);
    end

    // start while busy is ignored and input changes do not disturb the sum
    $display("[TB] start during RUN");
    applyStimulus(32'h12345678, 32'h11111111, 1'b1);
    a     = 32'h0;
    b     = 32'h0;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checkOutput("ignored_start pulses", 32'(pulses), 32'd1);
    checkOutput("ignored_start sum", sum, 32'h2345678A);

    // back-to-back: start in the DONE cycle
    $display("[TB] back-to-back");
    applyStimulus(32'd1, 32'd2, 1'b0);
    waitDone(cyc, bcyc);
    checkOutput("b2b first sum", sum, 32'd3);
    a     = 32'd5;
    b     = 32'd6;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b busy_no_idle", {31'd0, busy}, 32'd1);
    checkOutput("b2b sum_hold_run", sum, 32'd3);
    waitDone(cyc, bcyc);
    checkOutput("b2b latency", 32'(cyc), 32'd4);
    checkOutput("b2b sum", sum, 32'h0000000B);

    // reset on the second RUN cycle
    $display("[TB] reset mid-RUN");
    @(negedge clk);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort sum", sum, 32'd0);
    checkOutput("abort cout", {31'd0, cout}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checkOutput("abort no_done", 32'(pulses), 32'd0);
    checkOutput("abort sum_after", sum, 32'd0);
    runVector('{32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0}, 90);

    // reset wins over start in the same cycle
    $display("[TB] reset priority");
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst_prio busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("rst_prio busy_later", {31'd0, busy}, 32'd0);
    checkOutput("rst_prio sum", sum, 32'd0);

    // single-digit configuration
    $display("[TB] WIDTH=8 DIGIT=8");
    a8     = 8'hF0;
    b8     = 8'h0F;
    cin8   = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("w8 busy", {31'd0, busy8}, 32'd1);
    cyc = 0;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("w8 latency", 32'(cyc), 32'd1);
    checkOutput("w8 sum", {24'd0, sum8}, 32'h00);
    checkOutput("w8 cout", {31'd0, cout8}, 32'd1);
`ifdef SEQ_ADDER_OVF_EN
    checkOutput("w8 ovf", {31'd0, ovf8}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter DIGIT, default 8: bits added per clock; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an addition.
REQ-006 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry into bit 0.
REQ-009 SHALL have port busy  output  1  high while an addition is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-011 SHALL have port sum  output  WIDTH  registered result.
REQ-012 SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 IDLE: busy=0 and done=0; start=1 SHALL latch a, b and cin, clear the digit index, load the internal carry with cin, and go to RUN.
REQ-015 RUN: busy=1; each cycle SHALL add digit k (bits k*DIGIT+DIGIT-1..k*DIGIT) of the latched operands plus the internal carry, using a DIGIT-bit ripple of full-adder cells (s = a^b^c, cout = majority).
REQ-016 RUN: each cycle SHALL store the digit result into an internal result register, update the internal carry, and increment k.
REQ-017 RUN: after digit N-1 is added, SHALL go to DONE; RUN therefore lasts exactly N cycles.
REQ-018 DONE lasts one cycle: done=1, busy=0, sum and cout hold the new result; then SHALL go to IDLE, unless start=1, in which case it goes straight to RUN with new operands latched.
REQ-019 Latency SHALL be: start sampled at edge t gives done=1 in the cycle after edge t+N.
REQ-020 start while busy=1 SHALL be ignored, with no effect on operands, state or outputs.
REQ-021 sum and cout SHALL update only on entry to DONE and SHALL hold their value otherwise, including through later IDLE and RUN cycles.
REQ-022 When N=1, RUN SHALL last one cycle and the result SHALL equal a single WIDTH-bit addition.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL equal bit WIDTH of a+b+cin.
REQ-024 Input a, b and cin changes after the start cycle SHALL NOT affect the result in progress.

Reset
REQ-025 While rst=1, at each rising clk edge, state SHALL become IDLE, busy=0, done=0, sum=0, cout=0 (and ovf=0 when compiled in), the internal carry and digit index SHALL be 0, and start SHALL be ignored.
REQ-026 rst asserted mid-RUN SHALL abort the operation, produce no done pulse, and leave sum=0.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro SEQ_ADDER_OVF_EN defined: SHALL add port ovf  output  1, two's-complement overflow, equal to carry into bit WIDTH-1 XOR cout, updated and held like sum.
REQ-029 Macro SEQ_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 WIDTH=32, DIGIT=8: a=0xFFFFFFFF, b=0x00000001, cin=0, start at edge t -> busy for 4 cycles, done in the cycle after edge t+4, sum=0x00000000, cout=1, ovf=0.
REQ-031 WIDTH=32, DIGIT=8: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1 (OVF_EN defined).
REQ-032 WIDTH=32, DIGIT=8: start a=0x12345678, b=0x11111111, cin=1; then start=1 again in RUN with a=0, b=0 -> second start ignored; sum=0x2345678A, exactly one done pulse.
REQ-033 Back-to-back: start=1 during the DONE cycle with a=5, b=6 -> new operation accepted without an IDLE cycle; next done gives sum=0x0000000B.
REQ-034 rst=1 on the 2nd RUN cycle -> busy=0, done never pulses, sum=0 and cout=0 afterward; a following operation completes correctly.
REQ-035 WIDTH=8, DIGIT=8: a=0xF0, b=0x0F, cin=1 -> done in the cycle after edge t+1, sum=0x00, cout=1.
